// File: rtl/mem_multi_wide_narrow_mux.sv
// Default memory interface types plus the multi-wide/narrow bank mux.
//
// mem_multi_wide_narrow_mux_pkg
//   Default request/response structs for a 64-bit narrow and a 512-bit wide
//   memory port. Each request is {q, q_valid}. Each response is {p, q_ready}.
//
// mem_multi_wide_narrow_mux
//   Shares NrPorts narrow banks between NrPorts narrow masters and
//   NrWidePorts wide masters. A wide transaction covers every bank at once.
//   Each bank takes one slice of the wide data and strobe.
//   Ports:
//     clk_i, rst_ni      clock, asynchronous active-low reset
//     in_narrow_req_i    narrow master requests, one per bank
//     in_narrow_rsp_o    narrow master responses, one per bank
//     in_wide_req_i      wide master requests
//     in_wide_rsp_o      wide responses: q_ready and assembled p.data
//     in_wide_rvalid_o   one-cycle pulse: p.data is valid for that wide port
//     out_req_o          bank requests
//     out_rsp_i          bank responses
//
// Handshake: a request transfers in a cycle where q_valid and q_ready are both
// high. A master holds its request stable from q_valid until that cycle.
// Bank read data appears on p.data exactly MemoryLatency cycles after the
// bank's q handshake.
package mem_multi_wide_narrow_mux_pkg;

  typedef enum logic [3:0] {
    AMONone = 4'h0, AMOSwap = 4'h1, AMOAdd  = 4'h2, AMOAnd  = 4'h3,
    AMOOr   = 4'h4, AMOXor  = 4'h5, AMOMax  = 4'h6, AMOMaxu = 4'h7,
    AMOMin  = 4'h8, AMOMinu = 4'h9, AMOLR   = 4'hA, AMOSC   = 4'hB
  } amo_op_e;

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    amo_op_e     amo;
    logic [63:0] data;
    logic [7:0]  strb;
    logic [3:0]  user;
  } narrow_req_chan_t;

  typedef struct packed {
    narrow_req_chan_t q;
    logic             q_valid;
  } narrow_req_t;

  typedef struct packed {
    logic [63:0] data;
  } narrow_rsp_chan_t;

  typedef struct packed {
    narrow_rsp_chan_t p;
    logic             q_ready;
  } narrow_rsp_t;

  typedef struct packed {
    logic [31:0]  addr;
    logic         write;
    logic [511:0] data;
    logic [63:0]  strb;
    logic [3:0]   user;
  } wide_req_chan_t;

  typedef struct packed {
    wide_req_chan_t q;
    logic           q_valid;
  } wide_req_t;

  typedef struct packed {
    logic [511:0] data;
  } wide_rsp_chan_t;

  typedef struct packed {
    wide_rsp_chan_t p;
    logic           q_ready;
  } wide_rsp_t;

endpackage

module mem_multi_wide_narrow_mux #(
  parameter int unsigned NarrowDataWidth = 64,
  parameter int unsigned WideDataWidth   = 512,
  parameter int unsigned NrWidePorts     = 2,
  parameter int unsigned MemoryLatency   = 1,
  parameter int unsigned MaxWideBurst    = 8,
  parameter type mem_narrow_req_t = mem_multi_wide_narrow_mux_pkg::narrow_req_t,
  parameter type mem_narrow_rsp_t = mem_multi_wide_narrow_mux_pkg::narrow_rsp_t,
  parameter type mem_wide_req_t   = mem_multi_wide_narrow_mux_pkg::wide_req_t,
  parameter type mem_wide_rsp_t   = mem_multi_wide_narrow_mux_pkg::wide_rsp_t,
  // Derived from the data widths; do not override.
  parameter int unsigned NrPorts = WideDataWidth / NarrowDataWidth
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  mem_narrow_req_t [NrPorts-1:0]     in_narrow_req_i,
  output mem_narrow_rsp_t [NrPorts-1:0]     in_narrow_rsp_o,
  input  mem_wide_req_t   [NrWidePorts-1:0] in_wide_req_i,
  output mem_wide_rsp_t   [NrWidePorts-1:0] in_wide_rsp_o,
  output logic            [NrWidePorts-1:0] in_wide_rvalid_o,
  output mem_narrow_req_t [NrPorts-1:0]     out_req_o,
  input  mem_narrow_rsp_t [NrPorts-1:0]     out_rsp_i
);

  localparam int unsigned IdW       = (NrWidePorts > 1) ? $clog2(NrWidePorts) : 1;
  localparam int unsigned CntW      = $clog2(MaxWideBurst + 1);
  localparam int unsigned NStrbW    = NarrowDataWidth / 8;

  // Arbiter FSM: IDLE picks a new owner, BUSY holds the lock until every
  // bank has granted its slice.
  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StBusy = 1'b1;

  logic [0:0]         state_q, state_d;
  logic [IdW-1:0]     owner_q, owner_d;
  logic [IdW-1:0]     rr_q, rr_d;
  logic [NrPorts-1:0] mask_q, mask_d;
  logic [CntW-1:0]    burst_q, burst_d;

  logic [MemoryLatency-1:0][NrPorts-1:0] gnt_pipe_q;
  logic [MemoryLatency-1:0]              done_pipe_q;
  logic [MemoryLatency-1:0][IdW-1:0]     id_pipe_q;
  logic [NrPorts-1:0][NarrowDataWidth-1:0] buf_q;

  logic               sel_valid;
  logic [IdW-1:0]     sel_id;
  logic               narrow_slot;
  logic               wide_active;
  logic               done;
  logic               any_narrow_valid;
  logic [NrPorts-1:0] cur_gnt;
  logic [NrPorts-1:0] gnt_out;
  mem_wide_req_t      owner_req;
  logic [WideDataWidth-1:0] asm_data;

  // Owner selection. In BUSY the locked owner keeps driving. In IDLE, a
  // saturated burst counter turns the cycle into a narrow slot. Otherwise
  // the first valid port at or after the rr pointer wins in this same cycle.
  always_comb begin
    int unsigned idx;
    sel_valid   = 1'b0;
    sel_id      = owner_q;
    narrow_slot = 1'b0;
    idx         = 0;
    if (state_q == StBusy) begin
      sel_valid = 1'b1;
    end else if (burst_q >= CntW'(MaxWideBurst)) begin
      narrow_slot = 1'b1;
    end else begin
      for (int unsigned k = 0; k < NrWidePorts; k++) begin
        idx = (32'(rr_q) + k) % NrWidePorts;
        if (!sel_valid && in_wide_req_i[idx].q_valid) begin
          sel_valid = 1'b1;
          sel_id    = IdW'(idx);
        end
      end
    end
    // While reset is held the banks see plain narrow traffic.
    // No wide q_ready is raised in that time.
    wide_active = sel_valid & rst_ni;
  end

  assign owner_req = in_wide_req_i[sel_id];

  always_comb begin
    any_narrow_valid = 1'b0;
    for (int unsigned i = 0; i < NrPorts; i++) begin
      any_narrow_valid = any_narrow_valid | in_narrow_req_i[i].q_valid;
    end
  end

  // Bank drive. Banks already granted in this transaction go quiet, so a
  // stalled bank can finish without repeating writes on the others.
  always_comb begin
    out_req_o = in_narrow_req_i;
    cur_gnt   = '0;
    for (int unsigned i = 0; i < NrPorts; i++) begin
      in_narrow_rsp_o[i]         = out_rsp_i[i];
      in_narrow_rsp_o[i].q_ready = out_rsp_i[i].q_ready & ~wide_active;
      if (wide_active) begin
        out_req_o[i]         = '0;
        out_req_o[i].q_valid = ~mask_q[i];
        out_req_o[i].q.addr  = owner_req.q.addr;
        out_req_o[i].q.write = owner_req.q.write;
        out_req_o[i].q.user  = owner_req.q.user;
        out_req_o[i].q.amo   = mem_multi_wide_narrow_mux_pkg::AMONone;
        out_req_o[i].q.data  = owner_req.q.data[i*NarrowDataWidth +: NarrowDataWidth];
        out_req_o[i].q.strb  = owner_req.q.strb[i*NStrbW +: NStrbW];
        cur_gnt[i]           = ~mask_q[i] & out_rsp_i[i].q_ready;
      end
    end
    done = wide_active & (&(mask_q | cur_gnt));
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    mask_d  = mask_q;
    if (wide_active) begin
      if (done) begin
        state_d = StIdle;
        mask_d  = '0;
        rr_d    = (sel_id == IdW'(NrWidePorts - 1)) ? '0 : sel_id + IdW'(1);
      end else begin
        state_d = StBusy;
        owner_d = sel_id;
        mask_d  = mask_q | cur_gnt;
      end
    end
    // Count cycles in which wide traffic blocks a waiting narrow request.
    // The counter saturates because the check only needs ">= limit".
    if (narrow_slot) begin
      burst_d = '0;
    end else if (wide_active && any_narrow_valid) begin
      burst_d = (burst_q == CntW'(MaxWideBurst)) ? burst_q : burst_q + CntW'(1);
    end else begin
      burst_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      owner_q <= '0;
      rr_q    <= '0;
      mask_q  <= '0;
      burst_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      mask_q  <= mask_d;
      burst_q <= burst_d;
    end
  end

  // Grant bits and done/owner travel alongside the bank latency. The bank's
  // p.data is therefore valid exactly when its delayed grant bit pops out.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      gnt_pipe_q  <= '0;
      done_pipe_q <= '0;
      id_pipe_q   <= '0;
    end else begin
      gnt_pipe_q[0]  <= cur_gnt;
      done_pipe_q[0] <= done;
      id_pipe_q[0]   <= sel_id;
      for (int unsigned k = 1; k < MemoryLatency; k++) begin
        gnt_pipe_q[k]  <= gnt_pipe_q[k-1];
        done_pipe_q[k] <= done_pipe_q[k-1];
        id_pipe_q[k]   <= id_pipe_q[k-1];
      end
    end
  end

  assign gnt_out = gnt_pipe_q[MemoryLatency-1];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      buf_q <= '0;
    end else begin
      for (int unsigned i = 0; i < NrPorts; i++) begin
        if (gnt_out[i]) buf_q[i] <= out_rsp_i[i].p.data;
      end
    end
  end

  // Slices that arrive in the done cycle bypass the buffer. The next
  // transaction's first slice arrives one cycle later at the earliest.
  always_comb begin
    for (int unsigned i = 0; i < NrPorts; i++) begin
      asm_data[i*NarrowDataWidth +: NarrowDataWidth] =
        gnt_out[i] ? out_rsp_i[i].p.data : buf_q[i];
    end
  end

  always_comb begin
    for (int unsigned w = 0; w < NrWidePorts; w++) begin
      in_wide_rsp_o[w]         = '0;
      in_wide_rsp_o[w].q_ready = done & (sel_id == IdW'(w));
      in_wide_rsp_o[w].p.data  = asm_data;
      in_wide_rvalid_o[w]      = done_pipe_q[MemoryLatency-1] &
                                 (id_pipe_q[MemoryLatency-1] == IdW'(w));
    end
  end

endmodule
